// File: rtl/cdl_crc5_if.sv
// Serial bit stream and remainder bus between a USB token framer and the CRC5 engine.
interface cdl_crc5_if;
  logic       input_data;
  logic       reset_crc;
  logic [4:0] inverted_crc;

  modport master (
    output input_data,
    output reset_crc,
    input  inverted_crc
  );

  modport slave (
    input  input_data,
    input  reset_crc,
    output inverted_crc
  );
endinterface

// File: rtl/cdl_crc5.sv
// Serial USB CRC5 (x^5+x^2+1) generator/checker, one bit per clock, LSB-first.
// The output is the complemented remainder, which serves both TX append and RX residual check.
module cdl_crc5 #(
  parameter int unsigned        CRC_W    = 5,
  parameter logic [CRC_W-1:0]   POLY     = 5'b00101,
  parameter logic [CRC_W-1:0]   SEED     = 5'b11111,
  parameter logic [CRC_W-1:0]   RESIDUAL = 5'b01100
) (
  input  logic       clk,
  input  logic       n_rst,
  cdl_crc5_if.slave  crc_if
);

  logic [CRC_W-1:0] crc_reg;
  logic             fb;

  assign fb = crc_if.input_data ^ crc_reg[CRC_W-1];

  // Clear has priority over a data bit arriving in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_reg <= SEED;
    end else if (crc_if.reset_crc) begin
      crc_reg <= SEED;
    end else begin
      crc_reg <= {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  assign crc_if.inverted_crc = ~crc_reg;

endmodule

// File: tb/tb_cdl_crc5.sv
// Scoreboard bench for cdl_crc5: stimulus queues hand-computed remainders, a negedge monitor checks them.
module tb_cdl_crc5;

  logic tb_clk;
  logic n_rst;

  cdl_crc5_if crc_if ();

  cdl_crc5 #(
    .CRC_W    (5),
    .POLY     (5'b00101),
    .SEED     (5'b11111),
    .RESIDUAL (5'b01100)
  ) dut (
    .clk    (tb_clk),
    .n_rst  (n_rst),
    .crc_if (crc_if)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    string      name;
    logic [4:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_crc(input string name, input logic [4:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Monitor: the output is continuously valid, so every pending expectation is compared mid-cycle.
  always @(negedge tb_clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      if (crc_if.inverted_crc !== e.exp) begin
        n_fail++;
        $display("FAIL %s: inverted_crc=%b expected=%b", e.name, crc_if.inverted_crc, e.exp);
      end
    end
  end

  task automatic clk_bit(input logic clr, input logic b);
    crc_if.reset_crc  = clr;
    crc_if.input_data = b;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic feed_zeros(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) clk_bit(1'b0, 1'b0);
  endtask

  logic [4:0] crc_bits;
  logic [7:0] byte_a;
  logic [7:0] byte_b;

  initial begin
    n_rst             = 1'b0;
    crc_if.reset_crc  = 1'b1;
    crc_if.input_data = 1'b0;
    #2;
    expect_crc("por_reset", 5'b00000);
    @(posedge tb_clk);
    #1;
    n_rst = 1'b1;
    clk_bit(1'b1, 1'b0);
    expect_crc("clear_after_reset", 5'b00000);

    // SETUP token addr0/ep0: 11 zero bits.
    clk_bit(1'b0, 1'b0);
    expect_crc("first_zero_bit", 5'b00100);
    feed_zeros(10);
    expect_crc("setup_crc", 5'b01000);

    // Append the CRC MSB-first: 0,1,0,0,0.
    crc_bits = 5'b01000;
    clk_bit(1'b0, crc_bits[4]);
    expect_crc("rx_crc_bit0", 5'b10100);
    for (int i = 3; i >= 0; i--) clk_bit(1'b0, crc_bits[i]);
    expect_crc("rx_residual", 5'b10011);

    // Async reset mid-stream.
    clk_bit(1'b0, 1'b1);
    clk_bit(1'b0, 1'b1);
    n_rst = 1'b0;
    #1;
    expect_crc("async_reset_immediate", 5'b00000);
    clk_bit(1'b0, 1'b1);
    expect_crc("async_reset_held", 5'b00000);
    n_rst = 1'b1;
    #1;
    expect_crc("async_reset_released", 5'b00000);
    clk_bit(1'b0, 1'b0);
    expect_crc("after_async_first_bit", 5'b00100);

    // Clear beats a simultaneous 1 bit.
    for (int i = 0; i < 3; i++) begin
      clk_bit(1'b1, 1'b1);
      expect_crc($sformatf("clear_vs_data_%0d", i), 5'b00000);
    end
    clk_bit(1'b0, 1'b1);
    expect_crc("resume_after_clear", 5'b00001);

    // Clear with toggling data, then repeat the SETUP token.
    clk_bit(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, i[0]);
    expect_crc("clear_toggle", 5'b00000);
    feed_zeros(11);
    expect_crc("setup_crc_repeat", 5'b01000);

    // 0x00 then 0x84, each LSB-first.
    clk_bit(1'b1, 1'b0);
    byte_a = 8'h00;
    byte_b = 8'h84;
    for (int i = 0; i < 8; i++) clk_bit(1'b0, byte_a[i]);
    expect_crc("after_byte_00", 5'b10000);
    for (int i = 0; i < 8; i++) clk_bit(1'b0, byte_b[i]);
    expect_crc("after_byte_84", 5'b01010);

    @(negedge tb_clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
